mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Multi-cycle sequencer placing the single-cycle RV32 datapath on one shared single-port memory (von Neumann).
- Per instruction: fetch from PC, hold Instr stable, perform the load/store on the same port if required, then pulse a one-cycle commit that gates PC update and register writeback.
- Adds a bus-timeout watchdog and a retired-instruction counter.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before a bus error (>=1).
- NOP_INSTR, 32'h00000013, value presented on Instr during and after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC  input  XLEN  current PC from datapath.
- Instr  output  XLEN  registered instruction to datapath/controller.
- MemRead  input  1  decoded load request (valid while Instr held).
- MemWrite  input  1  decoded store request (valid while Instr held).
- Mem_WrAddr  input  XLEN  data address (ALUResult).
- Mem_WrData  input  XLEN  store data.
- ReadData  output  XLEN  registered load data to datapath.
- step  output  1  one-cycle commit pulse: PC register enable, RegWrite gate.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable, qualified by mem_req.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_rdata  input  XLEN  memory read data, valid with mem_ready.
- mem_ready  input  1  transfer complete this cycle.
- bus_error  output  1  sticky timeout flag.
- instret  output  32  count of step pulses.

Behaviour:
- Transfer completes on a rising edge where mem_req && mem_ready. mem_addr, mem_we and mem_wdata are held stable from assertion of mem_req until completion. mem_ready is ignored while mem_req=0.
- States: FETCH, DECODE, DATA, COMMIT, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On completion, Instr<=mem_rdata; go to DECODE.
- DECODE: one cycle, mem_req=0; MemRead/MemWrite sampled. If either is 1, go to DATA; else go to COMMIT.
- DATA: mem_req=1, mem_addr=Mem_WrAddr, mem_we=MemWrite, mem_wdata=Mem_WrData. On completion: for a load, ReadData<=mem_rdata; for a store, ReadData is unchanged. Go to COMMIT.
- MemRead and MemWrite both 1: treated as a store.
- COMMIT: step=1 for exactly one cycle, mem_req=0, instret increments (wraps at 2^32). Go to FETCH.
- step is 0 in every other state.
- Instr is held constant from the FETCH completion until the next FETCH completion, so the datapath sees stable decode through DATA and COMMIT.
- Latency with zero-wait memory:
  - non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT);
  - load/store: 4 cycles.
  - Each wait cycle adds 1.
- Watchdog: counter clears on entry to FETCH or DATA and increments each cycle mem_req=1 && mem_ready=0. When it reaches TIMEOUT: bus_error<=1, state<=HALT.
- HALT: mem_req=0, step=0. Left only by reset.
- Reset (asynchronous, any state, including mid-transfer):
  - state=FETCH;
  - Instr=NOP_INSTR, ReadData=0, instret=0, bus_error=0, watchdog=0;
  - step=0, mem_we=0.
  - mem_req deasserts immediately while reset is high and reasserts in FETCH on the first clock after release.
  - Any in-flight transfer is abandoned; the memory must tolerate request withdrawal.
- mem_ready asserted in DECODE/COMMIT/HALT: ignored, no state change.

Test Plan:
- Reset → PC=0, zero-wait memory returning 0x00500093 (addi x1,x0,5) → during reset: Instr=0x00000013, mem_req=0. After release: mem_req=1, mem_addr=0. step pulses in cycle 3, instret=1, mem_we never 1.
- Load: Instr=lw, MemRead=1, Mem_WrAddr=0x100, memory returns 0xDEADBEEF after 2 wait cycles → mem_addr=0x100 and mem_we=0 held for 3 cycles. ReadData=0xDEADBEEF the cycle step=1; step arrives 6 cycles after FETCH start.
- Store: MemWrite=1, Mem_WrAddr=0x204, Mem_WrData=0x12345678, zero-wait → exactly one cycle with mem_req=1, mem_we=1, mem_addr=0x204, mem_wdata=0x12345678. ReadData unchanged; step follows.
- Back-to-back: 10 non-memory instructions, zero-wait → step every 3rd cycle, instret=10, mem_addr tracks PC each FETCH.
- Timeout: TIMEOUT=16, mem_ready stuck 0 in FETCH → bus_error=1 after 16 waiting cycles. mem_req=0 and step=0 thereafter, even if mem_ready later rises. Reset clears bus_error.
- Reset during DATA wait (MemWrite=1) → mem_req and mem_we drop during reset, instret=0, Instr=NOP. After release, the first request is a fetch (mem_we=0, mem_addr=PC).

Source files
------------

// File: rtl/mem_sequencer.sv
// Multi-cycle fetch/data/commit sequencer that shares one single-port memory
// between instruction fetch and load/store, with a bus watchdog and retire counter.
module mem_sequencer #(
  parameter int              XLEN      = 32,
  parameter int              TIMEOUT   = 16,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] Instr,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] Mem_WrAddr,
  input  logic [XLEN-1:0] Mem_WrData,
  output logic [XLEN-1:0] ReadData,
  output logic            step,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            bus_error,
  output logic [31:0]     instret
);

  localparam int            WDW    = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] TO_CNT = WDW'(TIMEOUT);

  typedef enum logic [2:0] {FETCH, DECODE, DATA, COMMIT, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            is_store_q, is_store_d;
  logic            is_load_q, is_load_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [WDW-1:0]  wdog_inc;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     instret_q, instret_d;
  logic            req_c, we_c, step_c;
  logic [XLEN-1:0] addr_c;

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    is_load_d  = is_load_q;
    wdog_d     = wdog_q;
    bus_err_d  = bus_err_q;
    instret_d  = instret_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    step_c     = 1'b0;
    addr_c     = addr_q;
    case (state_q)
      FETCH: begin
        req_c  = 1'b1;
        addr_c = PC;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Address and data are captured here so the bus stays stable during waits.
        is_store_d = MemWrite;
        is_load_d  = MemRead & ~MemWrite;
        addr_d     = Mem_WrAddr;
        wdata_d    = Mem_WrData;
        wdog_d     = '0;
        state_d    = (MemRead | MemWrite) ? DATA : COMMIT;
      end
      DATA: begin
        req_c = 1'b1;
        we_c  = is_store_q;
        if (mem_ready) begin
          if (is_load_q) rdata_d = mem_rdata;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        step_c    = 1'b1;
        instret_d = instret_q + 32'd1;
        wdog_d    = '0;
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (req_c && !mem_ready) begin
      wdog_d = wdog_inc;
      if (wdog_inc == TO_CNT) begin
        bus_err_d = 1'b1;
        state_d   = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      instr_q    <= NOP_INSTR;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      is_load_q  <= 1'b0;
      wdog_q     <= '0;
      bus_err_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      is_load_q  <= is_load_d;
      wdog_q     <= wdog_d;
      bus_err_q  <= bus_err_d;
      instret_q  <= instret_d;
    end
  end

  // Request is withdrawn combinationally while reset is held.
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c & ~reset;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_q;
  assign step      = step_c;
  assign Instr     = instr_q;
  assign ReadData  = rdata_q;
  assign bus_error = bus_err_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: behavioural memory, a tiny datapath stand-in,
// an instruction-level reference model checked every cycle, plus literal expectations.
module tb_mem_sequencer;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          TO  = 16;

  logic        clk, reset;
  logic [31:0] PC, Instr, Mem_WrAddr, Mem_WrData, ReadData;
  logic        MemRead, MemWrite, step, mem_req, mem_we, mem_ready, bus_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] pc_tb, data_reg;
  int          wait_fetch, wait_data;
  logic        stuck, idle_ready, pc_pending;

  mem_sequencer #(.XLEN(32), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .step(step), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_error(bus_error), .instret(instret)
  );

  // Bench decode: opcode 03 load, 23 store, 7f asserts both; address is Instr[31:20].
  assign PC         = pc_tb;
  assign MemRead    = (Instr[6:0] == 7'h03) || (Instr[6:0] == 7'h7f);
  assign MemWrite   = (Instr[6:0] == 7'h23) || (Instr[6:0] == 7'h7f);
  assign Mem_WrAddr = {20'h0, Instr[31:20]};
  assign Mem_WrData = data_reg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Datapath stand-in: the PC register advances on the edge that ends a step cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pc_pending) begin
        pc_tb      = pc_tb + 32'd4;
        pc_pending = 1'b0;
      end
    end
  end

  // Memory responder and reference model, evaluated mid-cycle.
  int          cyc = 0;
  int          wcnt = 0;
  int          m_kind;   // 0 none, 1 fetch pending, 2 data pending
  int          m_from, m_step_at, m_waits;
  logic [31:0] m_instr, m_rd, m_ret, m_daddr;
  logic        m_halt, m_store, m_load;

  initial begin
    logic exp_req, exp_step;
    int   lim;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        wcnt = 0; mem_ready = 1'b0; mem_rdata = 32'h0;
        m_kind = 1; m_from = cyc + 1; m_step_at = -1; m_waits = 0;
        m_instr = NOP; m_rd = 32'h0; m_ret = 32'h0; m_halt = 1'b0;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_step", {31'h0, step}, 32'h0);
        check("rst_instr", Instr, NOP);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_buserr", {31'h0, bus_error}, 32'h0);
      end else begin
        if (mem_req) begin
          lim = (m_kind == 2) ? wait_data : wait_fetch;
          if (!stuck && wcnt >= lim) begin
            mem_ready = 1'b1;
            mem_rdata = mem_we ? 32'hBAD0BAD0 : mem[mem_addr[11:2]];
            wcnt = 0;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            wcnt++;
          end
        end else begin
          mem_ready = idle_ready;
          mem_rdata = 32'hBAD0BAD0;
          wcnt = 0;
        end

        exp_req  = !m_halt && m_kind != 0 && cyc >= m_from;
        exp_step = !m_halt && cyc == m_step_at;
        check("req", {31'h0, mem_req}, {31'h0, exp_req});
        check("step", {31'h0, step}, {31'h0, exp_step});
        check("instr", Instr, m_instr);
        check("rdata", ReadData, m_rd);
        check("instret", instret, m_ret);
        check("buserr", {31'h0, bus_error}, {31'h0, m_halt});
        if (exp_req) begin
          check("addr", mem_addr, (m_kind == 1) ? pc_tb : m_daddr);
          check("we", {31'h0, mem_we}, {31'h0, (m_kind == 2) && m_store});
          if (m_kind == 2 && m_store) check("wdata", mem_wdata, data_reg);
          if (mem_ready) begin
            if (m_kind == 1) begin
              m_instr = mem_rdata;
              m_load  = (mem_rdata[6:0] == 7'h03);
              m_store = (mem_rdata[6:0] == 7'h23) || (mem_rdata[6:0] == 7'h7f);
              m_daddr = {20'h0, mem_rdata[31:20]};
              if (m_load || m_store) begin
                m_kind = 2; m_from = cyc + 2; m_waits = 0;
              end else begin
                m_kind = 0; m_step_at = cyc + 2;
              end
            end else begin
              if (!m_store) m_rd = mem_rdata;
              m_kind = 0; m_step_at = cyc + 1;
            end
          end else begin
            m_waits++;
            if (m_waits == TO) m_halt = 1'b1;
          end
        end
        if (exp_step) begin
          m_ret++;
          m_kind = 1; m_from = cyc + 1; m_waits = 0; m_step_at = -1;
        end
        if (step) pc_pending = 1'b1;
      end
    end
  end

  // Runs from the current negedge until a step is seen; counts bus activity on the way.
  task automatic wait_step(input logic [31:0] a, input logic [31:0] d,
                           output int n, output int hit, output int wen, output int wdok);
    n = 0; hit = 0; wen = 0; wdok = 0;
    while (1) begin
      n++;
      if (mem_req && mem_addr == a) hit++;
      if (mem_req && mem_we) wen++;
      if (mem_req && mem_we && mem_wdata == d) wdok++;
      if (step || n >= 200) break;
      @(negedge clk);
    end
    if (!step) check("step_timeout", {31'h0, step}, 32'h1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int n, hit, wen, wdok, k;
    reset = 1'b1; pc_tb = 32'h0; data_reg = 32'h0; pc_pending = 1'b0;
    wait_fetch = 0; wait_data = 0; stuck = 1'b0; idle_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h00500093;
    mem[1]  = 32'h10002103;  // load from 0x100
    mem[2]  = 32'h20402023;  // store to 0x204
    mem[13] = 32'h2080007F;  // MemRead and MemWrite both, address 0x208
    mem[14] = 32'h20C02023;  // store to 0x20C
    mem[64] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("lit_rst_instr", Instr, 32'h00000013);
    check("lit_rst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // First instruction: non-memory, zero-wait.
    @(negedge clk);
    check("lit_fetch_req", {31'h0, mem_req}, 32'h1);
    check("lit_fetch_addr", mem_addr, 32'h0);
    wait_step(32'h0, 32'h0, n, hit, wen, wdok);
    check("lit_nonmem_cycles", n, 3);
    check("lit_nonmem_we", wen, 0);
    @(negedge clk);
    check("lit_instret_1", instret, 32'd1);

    // Load at PC 4 with two wait states.
    wait_data = 2;
    wait_step(32'h100, 32'h0, n, hit, wen, wdok);
    check("lit_load_cycles", n, 6);
    check("lit_load_addr_cycles", hit, 3);
    check("lit_load_we", wen, 0);
    check("lit_load_rdata", ReadData, 32'hDEADBEEF);

    // Store at PC 8, zero-wait.
    wait_data = 0; data_reg = 32'h12345678;
    @(negedge clk);
    wait_step(32'h204, 32'h12345678, n, hit, wen, wdok);
    check("lit_store_cycles", n, 4);
    check("lit_store_addr", hit, 1);
    check("lit_store_we", wen, 1);
    check("lit_store_wdata", wdok, 1);
    check("lit_store_rdata_kept", ReadData, 32'hDEADBEEF);
    check("lit_store_mem", mem[129], 32'h12345678);

    // Ten back-to-back non-memory instructions from PC 12, ready idling high.
    idle_ready = 1'b1;
    pulse_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      wait_step(32'h0, 32'h0, n, hit, wen, wdok);
      check("lit_b2b_cycles", n, 3);
      @(negedge clk);
    end
    check("lit_b2b_instret", instret, 32'd10);
    check("lit_b2b_pc", mem_addr, 32'h34);
    idle_ready = 1'b0;

    // MemRead and MemWrite together behave as a store.
    data_reg = 32'hCAFEF00D;
    wait_step(32'h208, 32'hCAFEF00D, n, hit, wen, wdok);
    check("lit_both_cycles", n, 4);
    check("lit_both_we", wen, 1);
    check("lit_both_wdata", wdok, 1);
    check("lit_both_rdata", ReadData, 32'h0);
    check("lit_both_mem", mem[130], 32'hCAFEF00D);

    // Reset during a waiting store.
    data_reg = 32'hA5A5A5A5; wait_data = 5;
    @(negedge clk);
    k = 0;
    while (!mem_we && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("lit_store_wait_reached", {31'h0, mem_we}, 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    wait_data = 0;
    @(negedge clk);
    check("lit_midrst_req", {31'h0, mem_req}, 32'h0);
    check("lit_midrst_we", {31'h0, mem_we}, 32'h0);
    check("lit_midrst_instret", instret, 32'h0);
    check("lit_midrst_instr", Instr, 32'h00000013);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("lit_postrst_req", {31'h0, mem_req}, 32'h1);
    check("lit_postrst_we", {31'h0, mem_we}, 32'h0);
    check("lit_postrst_addr", mem_addr, 32'h38);
    wait_step(32'h20C, 32'hA5A5A5A5, n, hit, wen, wdok);
    check("lit_retry_cycles", n, 4);
    check("lit_retry_wdata", wdok, 1);
    check("lit_retry_mem", mem[131], 32'hA5A5A5A5);

    // Watchdog: ready stuck low during fetch.
    stuck = 1'b1;
    pulse_reset();
    @(negedge clk);
    n = 0;
    while (!bus_error && n < 40) begin
      if (mem_req) n++;
      @(negedge clk);
    end
    check("lit_timeout_wait_cycles", n, 16);
    check("lit_timeout_flag", {31'h0, bus_error}, 32'h1);
    idle_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_halt_req", {31'h0, mem_req}, 32'h0);
      check("lit_halt_step", {31'h0, step}, 32'h0);
      check("lit_halt_flag", {31'h0, bus_error}, 32'h1);
    end
    @(posedge clk); #1 reset = 1'b1;
    stuck = 1'b0; idle_ready = 1'b0;
    @(negedge clk);
    check("lit_rst_clears_err", {31'h0, bus_error}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    wait_step(32'h0, 32'h0, n, hit, wen, wdok);
    check("lit_recover_cycles", n, 3);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
